// File: rtl/gfx_pkg.sv
// Shared graphics definitions: screen defaults, span-word layout and the
// constant-pitch row address helper used by the rectangle filler and the pixel-FIFO consumer.
package gfx_pkg;

   localparam int unsigned DEF_WIDTH  = 320;
   localparam int unsigned DEF_HEIGHT = 240;

   localparam int unsigned X_W    = 9;
   localparam int unsigned Y_W    = 8;
   localparam int unsigned PAGE_W = 2;
   localparam int unsigned ADDR_W = 18;
   localparam int unsigned CNT_W  = 10;
   localparam int unsigned SPAN_W = 32;

   // Span word as seen by the pixel FIFO: {zero, pixel, page, count, start address}
   typedef struct packed {
      logic              zero;
      logic              pixel;
      logic [PAGE_W-1:0] page;
      logic [CNT_W-1:0]  count;
      logic [ADDR_W-1:0] addr;
   } span_word_t;

   typedef struct packed {
      logic [X_W-1:0]    x;
      logic [Y_W-1:0]    y;
      logic [X_W-1:0]    w;
      logic [Y_W-1:0]    h;
      logic [PAGE_W-1:0] page;
      logic              pixel;
   } rect_cmd_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SETUP = 2'd1,
      ST_EMIT  = 2'd2
   } fill_state_t;

   // y * pitch for a constant pitch, built from shifted copies of y (256+64 for 320)
   function automatic logic [ADDR_W-1:0] row_base(input logic [Y_W-1:0] y,
                                                  input int unsigned   pitch);
      logic [ADDR_W-1:0] acc;
      acc = '0;
      for (int i = 0; i < int'(ADDR_W); i++) begin
         if (pitch[i]) begin
            acc = acc + (ADDR_W'(y) << i);
         end
      end
      return acc;
   endfunction

endpackage

// File: rtl/gfx_rect_clip.sv
// Combinational clip of a rectangle against the screen and its start address in
// graphics RAM.
module gfx_rect_clip
   import gfx_pkg::*;
#(
   parameter int unsigned g_width  = DEF_WIDTH,
   parameter int unsigned g_height = DEF_HEIGHT
) (
   input  logic [X_W-1:0]    x_i,
   input  logic [Y_W-1:0]    y_i,
   input  logic [X_W-1:0]    w_i,
   input  logic [Y_W-1:0]    h_i,
   output logic              empty_o,
   output logic [CNT_W-1:0]  wc_o,
   output logic [Y_W-1:0]    hc_o,
   output logic [ADDR_W-1:0] addr_o
);

   logic [31:0] x_room;
   logic [31:0] y_room;

   // Room values wrap when the origin is off-screen, but empty_o masks that case
   always_comb begin
      x_room  = 32'(g_width) - 32'(x_i);
      y_room  = 32'(g_height) - 32'(y_i);
      empty_o = (w_i == '0) || (h_i == '0) ||
                (32'(x_i) >= 32'(g_width)) || (32'(y_i) >= 32'(g_height));
      wc_o    = (32'(w_i) < x_room) ? CNT_W'(w_i) : CNT_W'(x_room);
      hc_o    = (32'(h_i) < y_room) ? h_i : Y_W'(y_room);
      addr_o  = row_base(y_i, g_width) + ADDR_W'(x_i);
   end

endmodule

// File: rtl/gfx_rect_filler.sv
// Rectangle fill engine: accepts one rectangle command, clips it and emits one
// span word per visible row into the pixel FIFO, top to bottom.
module gfx_rect_filler
   import gfx_pkg::*;
#(
   parameter int unsigned g_width  = DEF_WIDTH,
   parameter int unsigned g_height = DEF_HEIGHT
) (
   input  logic              clk_i,
   input  logic              rst_n_i,
   input  logic              cmd_valid_i,
   output logic              cmd_ready_o,
   input  logic [X_W-1:0]    cmd_x_i,
   input  logic [Y_W-1:0]    cmd_y_i,
   input  logic [X_W-1:0]    cmd_w_i,
   input  logic [Y_W-1:0]    cmd_h_i,
   input  logic [PAGE_W-1:0] cmd_page_i,
   input  logic              cmd_pixel_i,
   output logic              pfifo_we_o,
   output logic [SPAN_W-1:0] pfifo_data_o,
   input  logic              pfifo_full_i,
   output logic              busy_o
);

   fill_state_t       state_q, state_d;
   rect_cmd_t         cmd_q, cmd_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [Y_W-1:0]    rows_q, rows_d;

   logic              clip_empty;
   logic [CNT_W-1:0]  clip_wc;
   logic [Y_W-1:0]    clip_hc;
   logic [ADDR_W-1:0] clip_addr;
   span_word_t        span;

   gfx_rect_clip #(
      .g_width  (g_width),
      .g_height (g_height)
   ) u_clip (
      .x_i     (cmd_q.x),
      .y_i     (cmd_q.y),
      .w_i     (cmd_q.w),
      .h_i     (cmd_q.h),
      .empty_o (clip_empty),
      .wc_o    (clip_wc),
      .hc_o    (clip_hc),
      .addr_o  (clip_addr)
   );

   assign span = '{zero:  1'b0,
                   pixel: cmd_q.pixel,
                   page:  cmd_q.page,
                   count: cnt_q,
                   addr:  addr_q};

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         addr_q  <= '0;
         cnt_q   <= '0;
         rows_q  <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         addr_q  <= addr_d;
         cnt_q   <= cnt_d;
         rows_q  <= rows_d;
      end
   end

   // Next state, counters and outputs; the FIFO strobe follows full directly while emitting
   always_comb begin
      state_d      = state_q;
      cmd_d        = cmd_q;
      addr_d       = addr_q;
      cnt_d        = cnt_q;
      rows_d       = rows_q;
      cmd_ready_o  = 1'b0;
      busy_o       = 1'b0;
      pfifo_we_o   = 1'b0;
      pfifo_data_o = '0;

      unique case (state_q)
         ST_IDLE: begin
            cmd_ready_o = 1'b1;
            if (cmd_valid_i) begin
               cmd_d = '{x:     cmd_x_i,
                         y:     cmd_y_i,
                         w:     cmd_w_i,
                         h:     cmd_h_i,
                         page:  cmd_page_i,
                         pixel: cmd_pixel_i};
               state_d = ST_SETUP;
            end
         end
         ST_SETUP: begin
            busy_o = 1'b1;
            if (clip_empty) begin
               state_d = ST_IDLE;
            end else begin
               addr_d  = clip_addr;
               cnt_d   = clip_wc;
               rows_d  = clip_hc;
               state_d = ST_EMIT;
            end
         end
         ST_EMIT: begin
            busy_o       = 1'b1;
            pfifo_data_o = span;
            if (!pfifo_full_i) begin
               pfifo_we_o = 1'b1;
               addr_d     = addr_q + ADDR_W'(g_width);
               rows_d     = rows_q - Y_W'(1);
               if (rows_q == Y_W'(1)) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

endmodule
